// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL lock-qualified reset controller:
// state encoding and the loss-counter width.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_RUN       = 2'd2,
        ST_LOST      = 2'd3
    } pll_state_t;

    localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; async active-low reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_ctrl.sv
// Lock-qualified system reset and tick divider downstream of the PLL.
// Optional loss-event counter enabled by defining PLL_LOSS_COUNT_EN.
//
//   state     | meaning
//   WAIT_LOCK | reset held, waiting for synchronized lock
//   STABLE    | reset held, counting consecutive locked cycles
//   RUN       | reset released, tick divider running
//   LOST      | lock dropped, reset held for the minimum hold time
module pll_reset_ctrl
    import pll_rst_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int TICK_DIV           = 60,
    parameter int CNT_W              = 16
) (
    input  logic                  clock_in,
    input  logic                  reset_n,
    input  logic                  locked,
    output logic                  sys_rst_n,
    output logic                  tick,
    output logic [1:0]            ctrl_state,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    localparam int TDIV_W = $clog2(TICK_DIV);

    pll_state_t        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [TDIV_W-1:0] tdiv, tdiv_n;
    logic              rst_n_n, tick_n;
    logic              lock_s;

    sync_2ff u_lock_sync (
        .clk   (clock_in),
        .rst_n (reset_n),
        .d     (locked),
        .q     (lock_s)
    );

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_WAIT_LOCK;
            cnt       <= '0;
            tdiv      <= '0;
            sys_rst_n <= 1'b0;
            tick      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            tdiv      <= tdiv_n;
            sys_rst_n <= rst_n_n;
            tick      <= tick_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tdiv_n  = '0;
        rst_n_n = 1'b0;
        tick_n  = 1'b0;
        case (state)
            ST_WAIT_LOCK: begin
                cnt_n = '0;
                if (lock_s) state_n = ST_STABLE;
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_n = ST_WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_n = ST_RUN;
                    cnt_n   = '0;
                    rst_n_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_n = ST_LOST;
                    cnt_n   = '0;
                end else begin
                    rst_n_n = 1'b1;
                    if (tdiv == TDIV_W'(TICK_DIV - 1)) begin
                        tick_n = 1'b1;
                    end else begin
                        tdiv_n = tdiv + 1'b1;
                    end
                end
            end
            ST_LOST: begin
                // lock_s deliberately ignored so the hold time is always full length
                if (cnt == CNT_W'(RST_HOLD_CYCLES - 1)) begin
                    state_n = ST_WAIT_LOCK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = ST_WAIT_LOCK;
        endcase
    end

    assign ctrl_state = state;

`ifdef PLL_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] loss_q;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            loss_q <= '0;
        end else if (state == ST_RUN && !lock_s && loss_q != '1) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign loss_count = loss_q;
`else
    assign loss_count = '0;
`endif

endmodule
